// File: rtl/lader_pkg.sv
// lader_pkg: state encoding, fixed addresses and a state-class helper
// shared by the programm_lader boot loader and its counters.
package lader_pkg;

    // Zustand values double as LED code, so the encoding is fixed.
    typedef enum logic [2:0] {
        WARTEN         = 3'd0,
        GROESSE_ANF    = 3'd1,
        GROESSE_WARTEN = 3'd2,
        DATEN_ANF      = 3'd3,
        DATEN_WARTEN   = 3'd4,
        RAM_SCHREIBEN  = 3'd5,
        FERTIG         = 3'd6,
        FEHLER         = 3'd7
    } zustand_t;

    localparam logic [31:0] SD_HEADER_ADDR = 32'd0;
    localparam logic [31:0] SD_IMAGE_ADDR  = 32'd1;
    localparam logic [31:0] RAM_BASE_ADDR  = 32'd0;

    // States in which the loader waits on an external party.
    function automatic logic isWaitState(input zustand_t z);
        return (z == WARTEN) || (z == GROESSE_WARTEN) ||
               (z == DATEN_WARTEN) || (z == RAM_SCHREIBEN);
    endfunction

endpackage

// File: rtl/programm_lader_if.sv
// programm_lader_if: SD card and RAM side signals of the boot loader.
// The loader uses the master view, SD controller and RAM the slave view.
interface programm_lader_if;

    logic        SDBusy;
    logic        SDFertig;
    logic [31:0] SDDaten;
    logic [31:0] SDAdresse;
    logic        SDLesen;
    logic        RAMSchreiben;
    logic [31:0] RAMAdresse;
    logic [31:0] RAMDaten;
    logic        RAMGeschrieben;

    modport master (
        input  SDBusy, SDFertig, SDDaten, RAMGeschrieben,
        output SDAdresse, SDLesen, RAMSchreiben, RAMAdresse, RAMDaten
    );

    modport slave (
        output SDBusy, SDFertig, SDDaten, RAMGeschrieben,
        input  SDAdresse, SDLesen, RAMSchreiben, RAMAdresse, RAMDaten
    );

endinterface

// File: rtl/lader_pause_zaehler.sv
// lader_pause_zaehler: reloadable down-counter that stops at zero.
// Used for SD request spacing and as the per-state watchdog.
module lader_pause_zaehler #(
    parameter int unsigned       WIDTH  = 5,
    parameter logic [WIDTH-1:0]  RELOAD = '1
) (
    input  logic clk_25mhz,
    input  logic rst_n,
    input  logic reload,
    output logic isZero
);

    logic [WIDTH-1:0] count;

    // Reload has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            count <= RELOAD;
        end else if (reload) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign isZero = (count == '0);

endmodule

// File: rtl/programm_lader.sv
// programm_lader: boot loader copying a length-prefixed program image
// from the SD card into RAM, holding the CPU in reset until done.
// Optional watchdog on the wait states: define LADER_TIMEOUT_EN.
module programm_lader
    import lader_pkg::*;
#(
    parameter int unsigned MAX_WORDS    = 32768,
    parameter int unsigned PAUSE_CYCLES = 31
`ifdef LADER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 2**20
`endif
) (
    input  logic              clk_25mhz,
    input  logic              rst_n,
    programm_lader_if.master  bus,
    output logic              CPUReset,
    output logic              Fertig,
    output logic              Fehler,
    output logic [2:0]        Zustand
);

    localparam int unsigned PAUSE_W = $clog2(PAUSE_CYCLES + 1);

    zustand_t    state;
    zustand_t    stateNext;
    logic        sdLesen;
    logic        pauseZero;
    logic        timeout;
    logic [31:0] sdAdresse;
    logic [31:0] ramAdresse;
    logic [31:0] ramDaten;
    logic [31:0] remaining;
    logic        ramSchreiben;
    logic        fertigQ;
    logic        cpuResetQ;

    lader_pause_zaehler #(
        .WIDTH  (PAUSE_W),
        .RELOAD (PAUSE_W'(PAUSE_CYCLES))
    ) pauseZaehler (
        .clk_25mhz (clk_25mhz),
        .rst_n     (rst_n),
        .reload    (sdLesen),
        .isZero    (pauseZero)
    );

`ifdef LADER_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

    logic wdZero;
    logic wdReload;

    // The watchdog restarts on every state change and outside wait states,
    // so it only reaches zero after TIMEOUT_CYCLES in one wait state.
    assign wdReload = (stateNext != state) || !isWaitState(state);

    lader_pause_zaehler #(
        .WIDTH  (WD_W),
        .RELOAD (WD_W'(TIMEOUT_CYCLES - 1))
    ) watchdog (
        .clk_25mhz (clk_25mhz),
        .rst_n     (rst_n),
        .reload    (wdReload),
        .isZero    (wdZero)
    );

    assign timeout = wdZero && isWaitState(state);
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state <= WARTEN;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and the read strobe; reads only go out when SD is idle
    // and the request spacing has elapsed.
    always_comb begin
        stateNext = state;
        sdLesen   = 1'b0;
        unique case (state)
            WARTEN: begin
                if (!bus.SDBusy && pauseZero) stateNext = GROESSE_ANF;
            end
            GROESSE_ANF: begin
                if (!bus.SDBusy && pauseZero) begin
                    sdLesen   = 1'b1;
                    stateNext = GROESSE_WARTEN;
                end
            end
            GROESSE_WARTEN: begin
                if (bus.SDFertig) begin
                    if (bus.SDDaten > 32'(MAX_WORDS)) stateNext = FEHLER;
                    else if (bus.SDDaten == '0)       stateNext = FERTIG;
                    else                              stateNext = DATEN_ANF;
                end
            end
            DATEN_ANF: begin
                if (!bus.SDBusy && pauseZero) begin
                    sdLesen   = 1'b1;
                    stateNext = DATEN_WARTEN;
                end
            end
            DATEN_WARTEN: begin
                if (bus.SDFertig) stateNext = RAM_SCHREIBEN;
            end
            RAM_SCHREIBEN: begin
                if (bus.RAMGeschrieben) begin
                    stateNext = (remaining == 32'd1) ? FERTIG : DATEN_ANF;
                end
            end
            FERTIG: ;
            FEHLER: ;
            default: stateNext = FEHLER;
        endcase
        if (timeout) stateNext = FEHLER;
    end

    // Address, data and word-count registers; decisions follow stateNext
    // so a watchdog abort never starts or completes a RAM write.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            sdAdresse    <= SD_HEADER_ADDR;
            ramAdresse   <= RAM_BASE_ADDR;
            ramDaten     <= '0;
            ramSchreiben <= 1'b0;
            remaining    <= '0;
            fertigQ      <= 1'b0;
            cpuResetQ    <= 1'b1;
        end else begin
            fertigQ   <= (state == FERTIG);
            cpuResetQ <= (state != FERTIG);
            case (state)
                GROESSE_WARTEN: begin
                    if (stateNext == DATEN_ANF) begin
                        remaining  <= bus.SDDaten;
                        sdAdresse  <= SD_IMAGE_ADDR;
                        ramAdresse <= RAM_BASE_ADDR;
                    end
                end
                DATEN_WARTEN: begin
                    if (stateNext == RAM_SCHREIBEN) begin
                        ramDaten     <= bus.SDDaten;
                        ramSchreiben <= 1'b1;
                    end
                end
                RAM_SCHREIBEN: begin
                    if (stateNext != RAM_SCHREIBEN) begin
                        ramSchreiben <= 1'b0;
                        if (stateNext != FEHLER) begin
                            ramAdresse <= ramAdresse + 32'd1;
                            sdAdresse  <= sdAdresse + 32'd1;
                            remaining  <= remaining - 32'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.SDLesen      = sdLesen;
    assign bus.SDAdresse    = sdAdresse;
    assign bus.RAMSchreiben = ramSchreiben;
    assign bus.RAMAdresse   = ramAdresse;
    assign bus.RAMDaten     = ramDaten;
    assign CPUReset         = cpuResetQ;
    assign Fertig           = fertigQ;
    assign Fehler           = (state == FEHLER);
    assign Zustand          = state;

endmodule

// File: tb/tb_programm_lader.sv
// tb_programm_lader: directed bench with an SD card model, a RAM model and
// scoreboard queues for expected SD addresses and RAM writes.
module tb_programm_lader;

    localparam int unsigned MAXW  = 32768;
    localparam int unsigned PAUSE = 31;
`ifdef LADER_TIMEOUT_EN
    localparam int unsigned TOUT      = 64;
    localparam int          BUSY_LONG = 40;
`else
    localparam int          BUSY_LONG = 100;
`endif

    localparam logic [2:0] Z_WARTEN       = 3'd0;
    localparam logic [2:0] Z_DATEN_WARTEN = 3'd4;
    localparam logic [2:0] Z_FERTIG       = 3'd6;
    localparam logic [2:0] Z_FEHLER       = 3'd7;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       cpuReset;
    logic       fertig;
    logic       fehler;
    logic [2:0] zustand;

    programm_lader_if bus();

    always #20 clk = ~clk;

    programm_lader #(
        .MAX_WORDS    (MAXW),
        .PAUSE_CYCLES (PAUSE)
`ifdef LADER_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TOUT)
`endif
    ) dut (
        .clk_25mhz (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .CPUReset  (cpuReset),
        .Fertig    (fertig),
        .Fehler    (fehler),
        .Zustand   (zustand)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          cycle       = 0;
    logic [31:0] sdMem  [0:15];
    logic [31:0] ramMem [0:15];
    logic [31:0] expSdAddr [$];
    logic [63:0] expWrite  [$];
    bit          sdPending;
    int          sdDelay;
    logic [31:0] sdReqAddr;
    bit          headerOnly;
    int          busyLeft;
    int          ackDelay;
    bit          ramActive;
    int          ramWait;
    logic [31:0] heldAddr;
    logic [31:0] heldData;
    int          writesSeen;
    int          lastLesen;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // SD card and RAM behaviour for one cycle, run at each falling edge.
    task automatic modelStep();
        logic        lesen;
        logic        schreiben;
        logic [31:0] sdAddr;
        logic [31:0] rAddr;
        logic [31:0] rData;
        logic [63:0] expPair;
        lesen     = bus.SDLesen;
        schreiben = bus.RAMSchreiben;
        sdAddr    = bus.SDAdresse;
        rAddr     = bus.RAMAdresse;
        rData     = bus.RAMDaten;

        if (lesen) begin
            checkOutput("lesenBeiBusy", {31'd0, bus.SDBusy}, 32'd0);
            checkOutput("lesenAbstand", (cycle - lastLesen >= int'(PAUSE) + 1) ? 32'd1 : 32'd0, 32'd1);
            lastLesen = cycle;
            if (expSdAddr.size() == 0) checkOutput("sdAdresseUnerwartet", sdAddr, 32'hFFFF_FFFF);
            else                       checkOutput("sdAdresse", sdAddr, expSdAddr.pop_front());
            sdPending = 1'b1;
            sdDelay   = 2;
            sdReqAddr = sdAddr;
        end

        bus.SDFertig = 1'b0;
        bus.SDDaten  = 32'hDEAD_0000 | 32'(cycle);
        if (sdPending && !lesen) begin
            if (sdDelay == 0) begin
                sdPending = 1'b0;
                if (!headerOnly || sdReqAddr == 32'd0) begin
                    bus.SDFertig = 1'b1;
                    bus.SDDaten  = sdMem[sdReqAddr[3:0]];
                end
            end else begin
                sdDelay--;
            end
        end

        if (busyLeft > 0) busyLeft--;
        bus.SDBusy = (busyLeft > 0);

        if (bus.RAMGeschrieben) begin
            checkOutput("schreibenNachAck", {31'd0, schreiben}, 32'd0);
            bus.RAMGeschrieben = 1'b0;
            ramActive = 1'b0;
        end else if (schreiben) begin
            if (!ramActive) begin
                ramActive = 1'b1;
                ramWait   = ackDelay;
                heldAddr  = rAddr;
                heldData  = rData;
                writesSeen++;
                if (expWrite.size() == 0) begin
                    checkOutput("ramSchreibenUnerwartet", rAddr, 32'hFFFF_FFFF);
                end else begin
                    expPair = expWrite.pop_front();
                    checkOutput("ramAdresse", rAddr, expPair[63:32]);
                    checkOutput("ramDaten", rData, expPair[31:0]);
                end
            end else begin
                checkOutput("ramAdresseStabil", rAddr, heldAddr);
                checkOutput("ramDatenStabil", rData, heldData);
            end
            if (ramWait == 0) begin
                bus.RAMGeschrieben = 1'b1;
                ramMem[heldAddr[3:0]] = heldData;
            end else begin
                ramWait--;
            end
        end else if (ramActive) begin
            checkOutput("ramSchreibenGehalten", 32'd0, 32'd1);
            ramActive = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cycle++;
        modelStep();
    endtask

    task automatic waitZustand(input string tag, input logic [2:0] target, input int budget);
        int used = 0;
        while (zustand !== target && used < budget) begin
            tick();
            used++;
        end
        checkOutput(tag, {29'd0, zustand}, {29'd0, target});
    endtask

    task automatic checkResetValues();
        checkOutput("resetSDLesen", {31'd0, bus.SDLesen}, 32'd0);
        checkOutput("resetSDAdresse", bus.SDAdresse, 32'd0);
        checkOutput("resetRAMSchreiben", {31'd0, bus.RAMSchreiben}, 32'd0);
        checkOutput("resetRAMAdresse", bus.RAMAdresse, 32'd0);
        checkOutput("resetRAMDaten", bus.RAMDaten, 32'd0);
        checkOutput("resetCPUReset", {31'd0, cpuReset}, 32'd1);
        checkOutput("resetFertig", {31'd0, fertig}, 32'd0);
        checkOutput("resetFehler", {31'd0, fehler}, 32'd0);
        checkOutput("resetZustand", {29'd0, zustand}, {29'd0, Z_WARTEN});
    endtask

    // Pulls reset low between clock edges, checks the asynchronous reset
    // values, clears the models and releases reset two cycles later.
    task automatic applyReset(input int busy);
        #5 rst_n = 1'b0;
        #1 checkResetValues();
        bus.SDFertig       = 1'b0;
        bus.RAMGeschrieben = 1'b0;
        sdPending  = 1'b0;
        ramActive  = 1'b0;
        headerOnly = 1'b0;
        writesSeen = 0;
        lastLesen  = -1000;
        expSdAddr.delete();
        expWrite.delete();
        for (int i = 0; i < 16; i++) ramMem[i] = 32'd0;
        busyLeft   = busy;
        bus.SDBusy = (busy > 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Loads the SD image and queues the expected SD reads and RAM writes.
    task automatic applyStimulus(input logic [31:0] header, input logic [31:0] seed, input int ack);
        logic [31:0] w;
        ackDelay = ack;
        sdMem[0] = header;
        expSdAddr.push_back(32'd0);
        if (header <= 32'(MAXW)) begin
            for (int i = 0; i < int'(header); i++) begin
                w = seed + 32'(i) * 32'h11;
                sdMem[i + 1] = w;
                expSdAddr.push_back(32'(i + 1));
                expWrite.push_back({32'(i), w});
            end
        end
    endtask

    task automatic checkQueuesEmpty();
        checkOutput("sdQueueRest", 32'(expSdAddr.size()), 32'd0);
        checkOutput("writeQueueRest", 32'(expWrite.size()), 32'd0);
    endtask

    initial begin : globalLimit
        #2000000;
        $display("[TB] FAIL globalTimeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin : stimulus
        int used;
        bus.SDBusy         = 1'b1;
        bus.SDFertig       = 1'b0;
        bus.SDDaten        = 32'd0;
        bus.RAMGeschrieben = 1'b0;
        for (int i = 0; i < 16; i++) sdMem[i] = 32'd0;

        $display("[TB] three word image behind a busy SD card");
        applyReset(BUSY_LONG);
        applyStimulus(32'd3, 32'hA1, 1);
        waitZustand("t1Fertig", Z_FERTIG, 4000);
        checkOutput("t1FertigErsterTakt", {31'd0, fertig}, 32'd0);
        checkOutput("t1CpuResetErsterTakt", {31'd0, cpuReset}, 32'd1);
        tick();
        checkOutput("t1Fertig", {31'd0, fertig}, 32'd1);
        checkOutput("t1CpuReset", {31'd0, cpuReset}, 32'd0);
        checkOutput("t1Fehler", {31'd0, fehler}, 32'd0);
        checkOutput("t1Ram0", ramMem[0], 32'hA1);
        checkOutput("t1Ram1", ramMem[1], 32'hB2);
        checkOutput("t1Ram2", ramMem[2], 32'hC3);
        checkOutput("t1Writes", 32'(writesSeen), 32'd3);
        checkOutput("t1SDAdresseEnde", bus.SDAdresse, 32'd4);
        checkOutput("t1RAMAdresseEnde", bus.RAMAdresse, 32'd3);
        checkQueuesEmpty();
        repeat (20) tick();
        checkOutput("t1Terminal", {29'd0, zustand}, {29'd0, Z_FERTIG});
        checkOutput("t1FertigGehalten", {31'd0, fertig}, 32'd1);

        $display("[TB] empty image");
        applyReset(10);
        applyStimulus(32'd0, 32'd0, 1);
        waitZustand("t2Fertig", Z_FERTIG, 2000);
        tick();
        checkOutput("t2Fertig", {31'd0, fertig}, 32'd1);
        checkOutput("t2Fehler", {31'd0, fehler}, 32'd0);
        checkOutput("t2CpuReset", {31'd0, cpuReset}, 32'd0);
        checkOutput("t2Writes", 32'(writesSeen), 32'd0);
        checkQueuesEmpty();

        $display("[TB] oversized length word");
        applyReset(10);
        applyStimulus(32'(MAXW) + 32'd1, 32'd0, 1);
        waitZustand("t3Fehler", Z_FEHLER, 2000);
        checkOutput("t3Fehler", {31'd0, fehler}, 32'd1);
        checkOutput("t3CpuReset", {31'd0, cpuReset}, 32'd1);
        checkOutput("t3Fertig", {31'd0, fertig}, 32'd0);
        checkOutput("t3RAMSchreiben", {31'd0, bus.RAMSchreiben}, 32'd0);
        repeat (20) tick();
        checkOutput("t3Terminal", {29'd0, zustand}, {29'd0, Z_FEHLER});
        checkOutput("t3CpuResetGehalten", {31'd0, cpuReset}, 32'd1);
        checkOutput("t3Writes", 32'(writesSeen), 32'd0);
        checkQueuesEmpty();

        $display("[TB] RAM acknowledge delayed by five cycles");
        applyReset(10);
        applyStimulus(32'd2, 32'h5000_0001, 5);
        waitZustand("t4Fertig", Z_FERTIG, 3000);
        checkOutput("t4Ram0", ramMem[0], 32'h5000_0001);
        checkOutput("t4Ram1", ramMem[1], 32'h5000_0012);
        checkOutput("t4Writes", 32'(writesSeen), 32'd2);
        checkQueuesEmpty();

        $display("[TB] reset during the second of four words");
        applyReset(10);
        applyStimulus(32'd4, 32'h1234_5600, 1);
        used = 0;
        while (writesSeen < 2 && used < 3000) begin
            tick();
            used++;
        end
        checkOutput("t5ZweitesWort", 32'(writesSeen), 32'd2);
        applyReset(10);
        applyStimulus(32'd4, 32'h1234_5600, 1);
        waitZustand("t5Fertig", Z_FERTIG, 4000);
        tick();
        checkOutput("t5Fertig", {31'd0, fertig}, 32'd1);
        checkOutput("t5Ram0", ramMem[0], 32'h1234_5600);
        checkOutput("t5Ram1", ramMem[1], 32'h1234_5611);
        checkOutput("t5Ram2", ramMem[2], 32'h1234_5622);
        checkOutput("t5Ram3", ramMem[3], 32'h1234_5633);
        checkOutput("t5Writes", 32'(writesSeen), 32'd4);
        checkQueuesEmpty();

`ifdef LADER_TIMEOUT_EN
        $display("[TB] watchdog with SD data never arriving");
        applyReset(10);
        applyStimulus(32'd2, 32'h77, 1);
        headerOnly = 1'b1;
        waitZustand("t6DatenWarten", Z_DATEN_WARTEN, 2000);
        used = 0;
        while (zustand !== Z_FEHLER && used < 200) begin
            tick();
            used++;
        end
        checkOutput("t6TimeoutTakte", 32'(used), 32'(TOUT));
        checkOutput("t6Fehler", {31'd0, fehler}, 32'd1);
        checkOutput("t6RAMSchreiben", {31'd0, bus.RAMSchreiben}, 32'd0);
        checkOutput("t6Writes", 32'(writesSeen), 32'd0);
        expSdAddr.delete();
        expWrite.delete();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/programm_lader.md
Name: programm_lader

Overview:
Boot loader between SDKarte (upstream) and the RAM/CPU (downstream). It reads a length word and then a program image from the SD card, writes the image word by word into RAM starting at address 0, and holds the CPU in reset until the image is complete. It replaces the inline loader logic in the top level.

Parameters:
MAX_WORDS, 32768, RAM capacity in words; a larger length word is an error
PAUSE_CYCLES, 31, idle cycles required between two SD read requests (minimum gap the SD controller tolerates)
TIMEOUT_CYCLES, 2**20, watchdog limit per wait state (used only with LADER_TIMEOUT_EN)

Ports:
Clock  in  1  system clock, shared with CPU, RAM and SDKarte
Reset  in  1  asynchronous, active-low reset
SDBusy  in  1  SD controller busy/initialising
SDFertig  in  1  one-cycle pulse, SDDaten valid
SDDaten  in  32  word read from SD
SDAdresse  out  32  SD word address
SDLesen  out  1  one-cycle read request
RAMSchreiben  out  1  RAM write enable, level
RAMAdresse  out  32  RAM word address
RAMDaten  out  32  RAM write data
RAMGeschrieben  in  1  RAM write acknowledge
CPUReset  out  1  active-high CPU reset, held until load completes
Fertig  out  1  image loaded
Fehler  out  1  load aborted
Zustand  out  3  current state, for LEDs

Behaviour:
- Reset values: SDLesen=0, SDAdresse=0, RAMSchreiben=0, RAMAdresse=0, RAMDaten=0, CPUReset=1, Fertig=0, Fehler=0, Zustand=WARTEN(0). Pause counter=PAUSE_CYCLES. Remaining-word counter=0.
- States, with encoding: WARTEN=0, GROESSE_ANF=1, GROESSE_WARTEN=2, DATEN_ANF=3, DATEN_WARTEN=4, RAM_SCHREIBEN=5, FERTIG=6, FEHLER=7.
- Pause counter: reloads to PAUSE_CYCLES whenever SDLesen is asserted. Otherwise it decrements to 0 and saturates there.
- WARTEN: when SDBusy=0 and pause=0, go to GROESSE_ANF.
- GROESSE_ANF: SDAdresse=0, SDLesen=1 for exactly one cycle, then GROESSE_WARTEN.
- GROESSE_WARTEN: on SDFertig, latch N=SDDaten.
  - N>MAX_WORDS: go to FEHLER.
  - N=0: go to FERTIG.
  - Otherwise remaining=N, SDAdresse=1, RAMAdresse=0, go to DATEN_ANF.
- DATEN_ANF: wait until SDBusy=0 and pause=0, pulse SDLesen for one cycle, then DATEN_WARTEN.
- DATEN_WARTEN: on SDFertig, register RAMDaten=SDDaten, assert RAMSchreiben, go to RAM_SCHREIBEN.
- RAM_SCHREIBEN: hold RAMSchreiben, RAMAdresse and RAMDaten stable until RAMGeschrieben=1. In that cycle:
  - deassert RAMSchreiben;
  - RAMAdresse+1, SDAdresse+1, remaining-1;
  - if remaining was 1, go to FERTIG, else DATEN_ANF.
- FERTIG: Fertig=1 and CPUReset=0 from the cycle after entry. The state is terminal until Reset.
- FEHLER: Fehler=1, CPUReset stays 1. The state is terminal until Reset.
- Simultaneous events and edge cases:
  - SDFertig outside a *_WARTEN state is ignored.
  - RAMGeschrieben outside RAM_SCHREIBEN is ignored.
  - SDLesen is never asserted while SDBusy=1.
- Reset mid-operation: all registers return to reset values and CPUReset=1 immediately (asynchronously). The load then restarts from WARTEN.
- Width rules: all addresses are 32-bit unsigned. N is compared unsigned against MAX_WORDS. There is no wrap: N≤MAX_WORDS bounds RAMAdresse to MAX_WORDS-1.
- Latency per word: ≥ PAUSE_CYCLES+1 cycles from one SDLesen to the next.

Optional Feature:
LADER_TIMEOUT_EN
- Defined: a watchdog counts cycles spent in WARTEN, GROESSE_WARTEN, DATEN_WARTEN and RAM_SCHREIBEN. It clears on every state change. Reaching TIMEOUT_CYCLES forces FEHLER and deasserts RAMSchreiben.
- Undefined: no watchdog; wait states wait indefinitely.

Decomposition:
- Package lader_pkg holds:
  - the state typedef and its encodings (Zustand values above);
  - SD header word address (0) and image start address (1);
  - RAM base address (0).
- One natural sub-module, lader_pause_zaehler: the reloadable, saturating down-counter for request spacing. Instantiated twice: pause counter, and the watchdog under LADER_TIMEOUT_EN.

Test Plan:
- SD model with SDBusy=1 for 100 cycles, header N=3, data A1,B2,C3 -> RAM[0..2]=A1,B2,C3; Fertig=1; CPUReset falls one cycle after FERTIG; SDAdresse sequence 0,1,2,3.
- Header N=0 -> FERTIG with no RAMSchreiben pulse; Fertig=1 and Fehler=0.
- Header N=MAX_WORDS+1 -> FEHLER with Zustand=7, CPUReset=1 and no RAM write.
- RAM acknowledge delayed 5 cycles -> RAMSchreiben, RAMAdresse and RAMDaten stable for all 5 cycles; exactly one write per word.
- Reset pulled low during word 2 of 4 -> outputs return to reset values asynchronously; after release the full load restarts and RAM[0..3] is correct.
- With LADER_TIMEOUT_EN and TIMEOUT_CYCLES=64, SDFertig never arrives after the first data request -> FEHLER after 64 cycles in DATEN_WARTEN.
